divide_share_arbiter: RTL and testbench

- Shares one combinational newton_raphson_divide_16 instance between NUM_REQ requesters.
- Round-robin arbitration picks one requester. The block registers that requester's operands onto the divider inputs and waits SETTLE_CYCLES for the divider output to settle.
- It then captures Q and returns it, tagged with the requester ID, over a valid/ready response channel.
- Sits between client blocks and the single divider; the divider is instantiated beside it at top level.

---
 rtl/divide_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_divide_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_share_arbiter.sv
// divide_share_arbiter: time-shares one combinational 16-bit divider between
// NUM_REQ requesters using round-robin arbitration. The chosen operands are
// registered onto the divider, held SETTLE_CYCLES, then Q is returned tagged
// with the requester ID over a valid/ready response channel.
// Optional build macro: DIV_ZERO_CHECK_EN (zero divisor answered immediately
// with resp_q=0 and resp_err=1, skipping the settle wait).
module divide_share_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [16*NUM_REQ-1:0]     req_n,
  input  logic [16*NUM_REQ-1:0]     req_d,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic signed [15:0]        resp_q,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_err,
  output logic signed [15:0]        div_n,
  output logic signed [15:0]        div_d,
  input  logic signed [15:0]        div_q
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_id;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_resp_valid;
  logic signed [15:0]     r_resp_q;
  logic [ID_W-1:0]        r_resp_id;
  logic signed [15:0]     r_div_n;
  logic signed [15:0]     r_div_d;
`ifdef DIV_ZERO_CHECK_EN
  logic                   r_zero;
  logic                   r_resp_err;
`endif

  logic signed [15:0]     w_n_arr [NUM_REQ];
  logic signed [15:0]     w_d_arr [NUM_REQ];
  logic [ID_W-1:0]        w_scan;
  logic [ID_W-1:0]        w_gnt;
  logic                   w_any;
  logic signed [15:0]     w_sel_n;
  logic signed [15:0]     w_sel_d;

  // Unpack the flat operand buses into per-requester words
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_n_arr[i] = req_n[16*i +: 16];
      w_d_arr[i] = req_d[16*i +: 16];
    end
  end

  // Round-robin scan starting just after the last winner
  always_comb begin
    w_gnt  = r_rr_ptr;
    w_any  = 1'b0;
    w_scan = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && req_valid[w_scan]) begin
        w_any = 1'b1;
        w_gnt = w_scan;
      end
    end
  end

  assign w_sel_n = w_n_arr[w_gnt];
  assign w_sel_d = w_d_arr[w_gnt];

  // Offer the grant only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && !rst && w_any) req_ready[w_gnt] = 1'b1;
  end

  // Control FSM: accept, settle countdown, response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_q     <= '0;
      r_resp_id    <= '0;
      r_div_n      <= '0;
      r_div_d      <= 16'sd1;
`ifdef DIV_ZERO_CHECK_EN
      r_zero       <= 1'b0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_div_n  <= w_sel_n;
            r_div_d  <= w_sel_d;
            r_id     <= w_gnt;
            r_rr_ptr <= w_gnt;
            r_state  <= S_EVAL;
`ifdef DIV_ZERO_CHECK_EN
            // A zero divisor needs no settle time: answer on the next edge
            if (w_sel_d == 16'sd0) begin
              r_cnt  <= '0;
              r_zero <= 1'b1;
            end else begin
              r_cnt  <= CNT_INIT;
              r_zero <= 1'b0;
            end
`else
            r_cnt    <= CNT_INIT;
`endif
          end
        end
        S_EVAL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_id;
            r_state      <= S_RESP;
`ifdef DIV_ZERO_CHECK_EN
            if (r_zero) begin
              r_resp_q   <= '0;
              r_resp_err <= 1'b1;
            end else begin
              r_resp_q   <= div_q;
              r_resp_err <= 1'b0;
            end
`else
            r_resp_q     <= div_q;
`endif
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_q     = r_resp_q;
  assign resp_id    = r_resp_id;
  assign div_n      = r_div_n;
  assign div_d      = r_div_d;
`ifdef DIV_ZERO_CHECK_EN
  assign resp_err   = r_resp_err;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_divide_share_arbiter.sv
// Testbench for divide_share_arbiter with a behavioural divider beside it.
module tb_divide_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int SC   = 2;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_n;
  logic [16*NREQ-1:0] req_d;
  logic              resp_valid;
  logic              resp_ready;
  logic [15:0]       resp_q;
  logic [IDW-1:0]    resp_id;
  logic              resp_err;
  logic [15:0]       div_n;
  logic [15:0]       div_d;
  logic [15:0]       div_q;

  logic [15:0] tn [NREQ];
  logic [15:0] td [NREQ];

  int checks   = 0;
  int failures = 0;
  int model_ptr;

  divide_share_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_d(req_d), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_q(resp_q), .resp_id(resp_id), .resp_err(resp_err),
    .div_n(div_n), .div_d(div_d), .div_q(div_q)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_n[16*i +: 16] = tn[i];
      req_d[16*i +: 16] = td[i];
    end
  end

  // Combinational divider stand-in; zero divisor saturates
  always_comb begin
    if (div_d == 16'd0) div_q = 16'h7FFF;
    else div_q = 16'(int'($signed(div_n)) / int'($signed(div_d)));
  end

  function automatic logic [15:0] exp_q(input logic [15:0] n, input logic [15:0] d);
    int a, b;
    if (d == 16'd0) return ZCHK ? 16'h0000 : 16'h7FFF;
    a = int'($signed(n));
    b = int'($signed(d));
    return 16'(a / b);
  endfunction

  function automatic int exp_lat(input logic [15:0] d);
    return (ZCHK && d == 16'd0) ? 1 : SC;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  // One transaction from IDLE: wait for a grant, accept, wait for the response, handshake
  task automatic run_txn(input bit drop, output int g, output logic [NREQ-1:0] rdy,
                         output int lat, output logic [15:0] q, output logic [IDW-1:0] id,
                         output logic err, output logic [15:0] dn, output logic [15:0] dd);
    g = -1; lat = -1; rdy = '0; q = '0; id = '0; err = 1'b0; dn = '0; dd = '0;
    #1;
    for (int w = 0; w < 20 && req_ready == '0; w++) step();
    rdy = req_ready;
    if (rdy == '0) return;
    for (int i = NREQ - 1; i >= 0; i--) if (rdy[i[1:0]]) g = i;
    step();
    dn = div_n;
    dd = div_d;
    if (drop) req_valid[g[1:0]] = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      step();
      lat++;
    end
    if (!resp_valid) begin
      lat = -1;
      return;
    end
    q = resp_q; id = resp_id; err = resp_err;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin tn[i] = 16'(i + 1); td[i] = 16'd1; end
    step(); step();
    checks++; if (req_ready !== '0)     begin failures++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if (resp_valid !== 1'b0)  begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (resp_q !== 16'd0)     begin failures++; $display("FAIL reset_resp_q got=%h want=0", resp_q); end
    checks++; if (resp_id !== '0)       begin failures++; $display("FAIL reset_resp_id got=%0d want=0", resp_id); end
    checks++; if (resp_err !== 1'b0)    begin failures++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    checks++; if (div_n !== 16'd0)      begin failures++; $display("FAIL reset_div_n got=%h want=0", div_n); end
    checks++; if (div_d !== 16'd1)      begin failures++; $display("FAIL reset_div_d got=%h want=1", div_d); end
    req_valid = '0;
    rst = 1'b0;
    model_ptr = NREQ - 1;
    #1;
    checks++; if (req_ready !== '0)     begin failures++; $display("FAIL idle_no_req_ready got=%b want=0", req_ready); end
  endtask

  task automatic test_single();
    int g, lat; logic [NREQ-1:0] rdy; logic [15:0] q, dn, dd; logic [IDW-1:0] id; logic err;
    tn[0] = 16'd8; td[0] = 16'd2; req_valid = 4'b0001;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 0)          begin failures++; $display("FAIL single_grant got=%0d want=0", g); end
    checks++; if (lat != SC)       begin failures++; $display("FAIL single_latency got=%0d want=%0d", lat, SC); end
    checks++; if (q !== 16'd4)     begin failures++; $display("FAIL single_q got=%h want=0004", q); end
    checks++; if (id !== 2'd0)     begin failures++; $display("FAIL single_id got=%0d want=0", id); end
    checks++; if (err !== 1'b0)    begin failures++; $display("FAIL single_err got=%b want=0", err); end
    checks++; if (dn !== 16'd8 || dd !== 16'd2) begin failures++; $display("FAIL single_div_ops got=%h/%h want=0008/0002", dn, dd); end
    model_ptr = 0;
    tn[2] = 16'hFFF8; td[2] = 16'd2; req_valid = 4'b0100;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 2)          begin failures++; $display("FAIL neg_grant got=%0d want=2", g); end
    checks++; if (q !== 16'hFFFC)  begin failures++; $display("FAIL neg_q got=%h want=fffc", q); end
    checks++; if (id !== 2'd2)     begin failures++; $display("FAIL neg_id got=%0d want=2", id); end
    model_ptr = 2;
  endtask

  task automatic test_fairness();
    int g, lat, eg; logic [NREQ-1:0] rdy; logic [15:0] q, dn, dd; logic [IDW-1:0] id; logic err;
    logic [15:0] wantq [4];
    wantq[0] = 16'd14; wantq[1] = 16'd4; wantq[2] = 16'd4; wantq[3] = 16'hFFFC;
    do_reset();
    tn[0] = 16'd239;   td[0] = 16'd17;
    tn[1] = 16'd20;    td[1] = 16'd5;
    tn[2] = 16'd8;     td[2] = 16'd2;
    tn[3] = 16'hFFF8;  td[3] = 16'd2;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      eg = pick(req_valid, model_ptr);
      run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
      checks++; if (g != k || eg != k) begin failures++; $display("FAIL rr_order_%0d got=%0d want=%0d", k, g, k); end
      checks++; if (rdy !== 4'(1 << k)) begin failures++; $display("FAIL rr_onehot_%0d got=%b", k, rdy); end
      checks++; if (q !== wantq[k])   begin failures++; $display("FAIL rr_q_%0d got=%h want=%h", k, q, wantq[k]); end
      checks++; if (id !== 2'(k))     begin failures++; $display("FAIL rr_id_%0d got=%0d want=%0d", k, id, k); end
      model_ptr = k;
    end
    req_valid = 4'b0001;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 0) begin failures++; $display("FAIL rr_reraise0 got=%0d want=0", g); end
    model_ptr = 0;
    req_valid = 4'b0011;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 1) begin failures++; $display("FAIL rr_pair_first got=%0d want=1", g); end
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 0) begin failures++; $display("FAIL rr_pair_second got=%0d want=0", g); end
    model_ptr = 0;
  endtask

  task automatic test_backpressure();
    int w, lat; logic [15:0] q0; logic [IDW-1:0] id0; int bad_hold;
    int g, eg; logic [NREQ-1:0] rdy; logic [15:0] q, dn, dd; logic [IDW-1:0] id; logic err;
    tn[1] = 16'd100; td[1] = 16'd7; req_valid = 4'b0010;
    #1;
    for (w = 0; w < 20 && req_ready == '0; w++) step();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b want=0010", req_ready); end
    step();
    req_valid = 4'b0000;
    tn[3] = 16'd50; td[3] = 16'd5; req_valid[3] = 1'b1;
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL bp_eval_ready got=%b want=0", req_ready); end
    lat = 0;
    while (!resp_valid && lat < 50) begin step(); lat++; end
    checks++; if (!resp_valid) begin failures++; $display("FAIL bp_resp_timeout got=0 want=1"); end
    q0 = resp_q; id0 = resp_id;
    checks++; if (q0 !== 16'd14 || id0 !== 2'd1) begin failures++; $display("FAIL bp_resp got=%h/%0d want=000e/1", q0, id0); end
    bad_hold = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (resp_valid !== 1'b1 || resp_q !== 16'd14 || resp_id !== 2'd1 || req_ready !== '0) bad_hold++;
    end
    checks++; if (bad_hold != 0) begin failures++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad_hold); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b want=0", resp_valid); end
    checks++; if (div_n !== 16'd100)   begin failures++; $display("FAIL bp_no_grant_on_hs got=%h want=0064", div_n); end
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_next_ready got=%b want=1000", req_ready); end
    model_ptr = 1;
    eg = pick(req_valid, model_ptr);
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != eg || q !== 16'd10) begin failures++; $display("FAIL bp_follow got=%0d/%h want=%0d/000a", g, q, eg); end
    model_ptr = 3;
  endtask

  task automatic test_reset_mid();
    int w, seen; int g, lat; logic [NREQ-1:0] rdy; logic [15:0] q, dn, dd; logic [IDW-1:0] id; logic err;
    tn[1] = 16'd30; td[1] = 16'd3; req_valid = 4'b0010;
    #1;
    for (w = 0; w < 20 && req_ready == '0; w++) step();
    step();
    req_valid = '0;
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_pre got=%b want=0", resp_valid); end
    rst = 1'b1;
    step();
    checks++; if (resp_valid !== 1'b0 || div_d !== 16'd1 || div_n !== 16'd0) begin
      failures++; $display("FAIL mid_reset got=v%b d=%h n=%h want=v0 d=0001 n=0000", resp_valid, div_d, div_n); end
    rst = 1'b0;
    model_ptr = NREQ - 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin step(); if (resp_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_dropped got=%0d responses want=0", seen); end
    tn[3] = 16'hFF9C; td[3] = 16'd7; req_valid = 4'b1010;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != pick(4'b1010, NREQ - 1) || g != 1) begin failures++; $display("FAIL mid_ptr_reset got=%0d want=1", g); end
    model_ptr = 1;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 3 || q !== 16'hFFF2 || id !== 2'd3) begin failures++; $display("FAIL mid_req3 got=%0d/%h/%0d want=3/fff2/3", g, q, id); end
    model_ptr = 3;
  endtask

  task automatic test_div_zero();
    int g, lat; logic [NREQ-1:0] rdy; logic [15:0] q, dn, dd; logic [IDW-1:0] id; logic err;
    tn[2] = 16'd5; td[2] = 16'd0; req_valid = 4'b0100;
    run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
    checks++; if (g != 2 || id !== 2'd2) begin failures++; $display("FAIL dz_grant got=%0d/%0d want=2/2", g, id); end
    checks++; if (lat != (ZCHK ? 1 : SC)) begin failures++; $display("FAIL dz_latency got=%0d want=%0d", lat, ZCHK ? 1 : SC); end
    checks++; if (err !== ZCHK) begin failures++; $display("FAIL dz_err got=%b want=%b", err, ZCHK); end
    checks++; if (q !== (ZCHK ? 16'h0000 : 16'h7FFF)) begin failures++; $display("FAIL dz_q got=%h want=%h", q, ZCHK ? 16'h0000 : 16'h7FFF); end
    checks++; if (dn !== 16'd5 || dd !== 16'd0) begin failures++; $display("FAIL dz_ops got=%h/%h want=0005/0000", dn, dd); end
    model_ptr = 2;
  endtask

  task automatic test_random();
    int g, lat, eg; logic [NREQ-1:0] rdy, m; logic [15:0] q, dn, dd; logic [IDW-1:0] id; logic err;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        tn[i] = 16'($urandom_range(0, 65535));
        td[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        if (td[i] == 16'hFFFF && tn[i] == 16'h8000) tn[i] = 16'd1;
      end
      m = 4'($urandom_range(1, 15));
      req_valid = m;
      eg = pick(m, model_ptr);
      run_txn(1'b1, g, rdy, lat, q, id, err, dn, dd);
      checks++;
      if (g != eg || id !== 2'(eg) || q !== exp_q(tn[eg], td[eg]) ||
          err !== (ZCHK && td[eg] == 16'd0) || lat != exp_lat(td[eg]) || dn !== tn[eg] || dd !== td[eg]) begin
        failures++;
        $display("FAIL rand_%0d got g=%0d id=%0d q=%h err=%b lat=%0d want g=%0d q=%h lat=%0d",
                 it, g, id, q, err, lat, eg, exp_q(tn[eg], td[eg]), exp_lat(td[eg]));
      end
      model_ptr = eg;
      req_valid = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0; model_ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin tn[i] = '0; td[i] = 16'd1; end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_div_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
